// File: rtl/cmd_host_pkg.sv
`default_nettype none
// cmd_host_pkg -- command word fields, target codes, status codes and FSM states. Rev 1.0
package cmd_host_pkg;

  localparam int CMD_TARGET_HI = 31;
  localparam int CMD_TARGET_LO = 24;

  localparam logic [7:0] C_TARGET_TAP  = 8'h01;
  localparam logic [7:0] C_TARGET_CTL  = 8'h02;
  localparam logic [7:0] C_TARGET_STAT = 8'h03;

  localparam int N_TAP_CTL_SIZE = 8;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_CMD   = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_RD_RSP   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  function automatic logic [7:0] cmd_target(input logic [31:0] cmd);
    return cmd[CMD_TARGET_HI:CMD_TARGET_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_host_timer.sv
`default_nettype none
// cmd_host_timer -- response timeout counter; expires on its TO_CYCLES-th enabled cycle, never wraps. Rev 1.0
module cmd_host_timer
  import cmd_host_pkg::*;
#(
  parameter int TO_W      = 16,
  parameter int TO_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TO_W-1:0] C_LAST = TO_W'(TO_CYCLES - 1);

  logic [TO_W-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmd_host.sv
`default_nettype none
// cmd_host -- one-outstanding command/response FIFO initiator with stale-response flush.
// Rev 1.0. Define CMD_HOST_TIMEOUT_EN to enable the response timeout (TIMEOUT status).
module cmd_host
  import cmd_host_pkg::*;
#(
  parameter int TO_W      = 16,
  parameter int TO_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_cmd,
  output logic        o_done_valid,
  input  logic        i_done_ready,
  output logic [31:0] o_done_data,
  output logic [1:0]  o_done_status,
  output logic [31:0] o_cmd_wrdata,
  output logic        o_cmd_wrreq,
  input  logic        i_cmd_waitreq,
  input  logic [31:0] i_rsp_rddata,
  output logic        o_rsp_rdreq,
  input  logic        i_rsp_waitreq,
  output logic [7:0]  o_stale_cnt
);

  state_t r_state;
  logic   w_rsp_avail;
  logic   w_flush;
  logic   w_wr;
  logic   w_expire;

  assign w_rsp_avail = !i_rsp_waitreq;
  // Anything in the rsp FIFO while idle belongs to an abandoned command.
  assign w_flush     = (r_state == S_IDLE) && w_rsp_avail;
  assign w_wr        = (r_state == S_WR_CMD) && !i_cmd_waitreq;

  assign o_req_ready  = (r_state == S_IDLE) && !w_rsp_avail;
  assign o_cmd_wrreq  = w_wr;
  assign o_rsp_rdreq  = w_flush || (r_state == S_RD_RSP);
  assign o_done_valid = (r_state == S_DONE);

`ifdef CMD_HOST_TIMEOUT_EN
  cmd_host_timer #(
    .TO_W      (TO_W),
    .TO_CYCLES (TO_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != S_WAIT_RSP),
    .i_en     ((r_state == S_WAIT_RSP) && i_rsp_waitreq),
    .o_expire (w_expire)
  );
`else
  // No timer: the wait state leaves only on a response; this folds to constant 0.
  assign w_expire = (TO_CYCLES < 1) && (TO_W < 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      o_cmd_wrdata  <= '0;
      o_done_data   <= '0;
      o_done_status <= ST_OK;
      o_stale_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_flush) begin
            if (o_stale_cnt != 8'hFF) o_stale_cnt <= o_stale_cnt + 8'd1;
          end else if (i_req_valid) begin
            o_cmd_wrdata <= i_req_cmd;
            r_state      <= S_WR_CMD;
          end
        end
        S_WR_CMD: begin
          if (w_wr) r_state <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (w_rsp_avail) begin
            r_state <= S_RD_RSP;
          end else if (w_expire) begin
            o_done_data   <= '0;
            o_done_status <= ST_TIMEOUT;
            r_state       <= S_DONE;
          end
        end
        S_RD_RSP: begin
          o_done_data   <= i_rsp_rddata;
          o_done_status <= ST_OK;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          if (i_done_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_host.sv
`default_nettype none
// tb_cmd_host -- scoreboard bench with cmd/rsp FIFO and executor model around cmd_host. Rev 1.0
module tb_cmd_host;
  import cmd_host_pkg::*;

  localparam int TO_C = 16;
  localparam int LIM  = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_cmd = '0;
  logic        o_done_valid;
  logic        i_done_ready = 1'b1;
  logic [31:0] o_done_data;
  logic [1:0]  o_done_status;
  logic [31:0] o_cmd_wrdata;
  logic        o_cmd_wrreq;
  logic        i_cmd_waitreq = 1'b0;
  logic [31:0] i_rsp_rddata = '0;
  logic        o_rsp_rdreq;
  logic        i_rsp_waitreq = 1'b1;
  logic [7:0]  o_stale_cnt;

  cmd_host #(.TO_W(16), .TO_CYCLES(TO_C)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_cmd(i_req_cmd),
    .o_done_valid(o_done_valid), .i_done_ready(i_done_ready),
    .o_done_data(o_done_data), .o_done_status(o_done_status),
    .o_cmd_wrdata(o_cmd_wrdata), .o_cmd_wrreq(o_cmd_wrreq), .i_cmd_waitreq(i_cmd_waitreq),
    .i_rsp_rddata(i_rsp_rddata), .o_rsp_rdreq(o_rsp_rdreq), .i_rsp_waitreq(i_rsp_waitreq),
    .o_stale_cnt(o_stale_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } pend_t;
  typedef struct { logic [1:0] st; logic [31:0] d; } exp_t;

  logic [31:0] rsp_q[$];
  pend_t       pend_q[$];
  pend_t       keep_q[$];
  exp_t        exp_rsp_q[$];
  logic [31:0] exp_cmd_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int dmin = 0, dmax = 6, ready_mode = 1, wq_mode = 1;
  bit drop_mode = 1'b0;
  int stale_exp = 0, acc_cnt = 0, wr_cnt = 0;
  int t_accept = 0, t_wrreq = 0, t_done = 0, t_rsp = 0;
  logic        smp_rdreq = 1'b0, smp_wr = 1'b0;
  logic [31:0] smp_wrdata = '0;
  logic        prev_dv = 1'b0;
  logic [31:0] held_data = '0, last_data = '0;
  logic [1:0]  held_st = '0, last_st = '0;

  // Loopback executor: response word derived from the command.
  function automatic logic [31:0] exec_rsp(input logic [31:0] cmd);
    if (cmd == 32'h0100_00A5) return 32'hDEAD_BEEF;
    return {cmd[15:0], cmd[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO / executor / requester-ready environment, updated just after each edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      rsp_q.delete();
      pend_q.delete();
    end else begin
      if (smp_rdreq && rsp_q.size() != 0) void'(rsp_q.pop_front());
      if (smp_wr && !drop_mode)
        pend_q.push_back('{cyc + int'($urandom_range(dmax, dmin)), exec_rsp(smp_wrdata)});
      keep_q = {};
      foreach (pend_q[i]) begin
        if (pend_q[i].due <= cyc) begin
          if (rsp_q.size() == 0) t_rsp = cyc;
          rsp_q.push_back(pend_q[i].data);
        end else begin
          keep_q.push_back(pend_q[i]);
        end
      end
      pend_q = keep_q;
    end
    #1;
    i_rsp_waitreq = (rsp_q.size() == 0);
    i_rsp_rddata  = (rsp_q.size() != 0) ? rsp_q[0] : 32'h0;
    i_cmd_waitreq = (wq_mode == 2) ? 1'b1 : (wq_mode == 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
    i_done_ready  = (ready_mode == 2) ? 1'b0 : (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      smp_rdreq = 1'b0;
      smp_wr    = 1'b0;
      prev_dv   = 1'b0;
    end else begin
      smp_rdreq  = o_rsp_rdreq;
      smp_wr     = o_cmd_wrreq;
      smp_wrdata = o_cmd_wrdata;
      if (o_rsp_rdreq) begin
        chk("flush_blocks_accept", {31'd0, o_req_ready}, 32'd0);
        chk("rdreq_fifo_nonempty", {31'd0, i_rsp_waitreq}, 32'd0);
      end
      if (i_req_valid && o_req_ready) begin
        acc_cnt++;
        t_accept = cyc;
        exp_cmd_q.push_back(i_req_cmd);
        if (drop_mode) begin e.st = ST_TIMEOUT; e.d = 32'h0; end
        else begin e.st = ST_OK; e.d = exec_rsp(i_req_cmd); end
        exp_rsp_q.push_back(e);
      end
      if (o_cmd_wrreq) begin
        wr_cnt++;
        t_wrreq = cyc;
        chk("wrreq_while_full", {31'd0, i_cmd_waitreq}, 32'd0);
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wrreq: got %h expected no write", o_cmd_wrdata);
        end else begin
          chk("cmd_wrdata", o_cmd_wrdata, exp_cmd_q.pop_front());
        end
      end
      if (o_done_valid) begin
        chk("no_strobe_or_ready_in_done", {29'd0, o_cmd_wrreq, o_rsp_rdreq, o_req_ready}, 32'd0);
        if (prev_dv) begin
          chk("done_data_stable", o_done_data, held_data);
          chk("done_status_stable", {30'd0, o_done_status}, {30'd0, held_st});
        end else begin
          t_done = cyc;
        end
        held_data = o_done_data;
        held_st   = o_done_status;
        if (i_done_ready) begin
          last_data = o_done_data;
          last_st   = o_done_status;
          if (exp_rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got %h/%b expected no response", o_done_data, o_done_status);
          end else begin
            e = exp_rsp_q.pop_front();
            chk("done_data", o_done_data, e.d);
            chk("done_status", {30'd0, o_done_status}, {30'd0, e.st});
          end
        end
      end
      prev_dv = o_done_valid && !i_done_ready;
    end
  end

  task automatic chk_reset();
    chk("rst_req_ready",   {31'd0, o_req_ready},   32'd1);
    chk("rst_done_valid",  {31'd0, o_done_valid},  32'd0);
    chk("rst_done_data",   o_done_data,            32'd0);
    chk("rst_done_status", {30'd0, o_done_status}, 32'd0);
    chk("rst_cmd_wrreq",   {31'd0, o_cmd_wrreq},   32'd0);
    chk("rst_rsp_rdreq",   {31'd0, o_rsp_rdreq},   32'd0);
    chk("rst_cmd_wrdata",  o_cmd_wrdata,           32'd0);
    chk("rst_stale_cnt",   {24'd0, o_stale_cnt},   32'd0);
  endtask

  task automatic send(input logic [31:0] cmd);
    int n = 0;
    i_req_valid = 1'b1;
    i_req_cmd   = cmd;
    @(negedge clk);
    while (!o_req_ready && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: got no req_ready for %0d cycles expected accept", n);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || rsp_q.size() != 0 || pend_q.size() != 0) && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) begin
      checks++; errors++;
      $display("FAIL %s_drain_timeout: got %0d cycles expected < %0d", name, n, LIM);
    end
    @(posedge clk); #1;
  endtask

  task automatic inject(input logic [31:0] w);
    pend_q.push_back('{cyc, w});
    stale_exp++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: basic transaction with latency checks.
    dmin = 3; dmax = 3;
    send(32'h0100_00A5);
    wait_drain("basic");
    chk("accept_to_wrreq", t_wrreq - t_accept, 32'd1);
    chk("rsp_to_done", t_done - t_rsp, 32'd2);
    chk("basic_data", last_data, 32'hDEAD_BEEF);

    // Directed: cmd FIFO full for 5 cycles after accept.
    n = wr_cnt;
    wq_mode = 2;
    send(32'h0200_1234);
    repeat (5) @(posedge clk);
    wq_mode = 1;
    wait_drain("full");
    chk("single_write", wr_cnt - n, 32'd1);
    chk("write_after_full", t_wrreq - t_accept, 32'd6);

`ifdef CMD_HOST_TIMEOUT_EN
    // Directed: executor drops the response.
    drop_mode = 1'b1;
    send(32'h0300_0042);
    wait_drain("timeout");
    drop_mode = 1'b0;
    chk("timeout_latency", t_done - t_wrreq, TO_C + 1);
    chk("timeout_status", {30'd0, last_st}, {30'd0, ST_TIMEOUT});
`endif

    // Late response lands while idle, then a new request arrives.
    inject(32'hBAD0_0001);
    @(posedge clk); #1;
    send(32'h0400_0777);
    wait_drain("stale");
    chk("stale_cnt_one", {24'd0, o_stale_cnt}, sat255(stale_exp));

    // Requester stalls done_ready for 10 cycles.
    ready_mode = 2;
    send(32'h0500_5555);
    n = 0;
    while (!o_done_valid && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) begin
      checks++; errors++;
      $display("FAIL hold_done_timeout: got no done_valid expected done");
    end
    repeat (10) @(negedge clk);
    ready_mode = 1;
    wait_drain("hold");

    // Randomized traffic.
    ready_mode = 0; wq_mode = 0; dmin = 0; dmax = 6;
    for (int i = 0; i < 40; i++) begin
      send($urandom());
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    ready_mode = 1; wq_mode = 1;
    wait_drain("random");

    // Reset while waiting for a response.
    drop_mode = 1'b1;
    send(32'h0600_CAFE);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    exp_rsp_q.delete();
    exp_cmd_q.delete();
    stale_exp = 0;
    drop_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stale counter saturation.
    for (int i = 0; i < 300; i++) inject(32'h5000_0000 + i);
    wait_drain("saturate");
    chk("stale_cnt_sat", {24'd0, o_stale_cnt}, sat255(stale_exp));
    send(32'h0700_0001);
    wait_drain("post_sat");
    chk("writes_eq_accepts", wr_cnt, acc_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
